// File: rtl/msrv32_dmem_responder_if.sv
// Data-memory bus between the RV32I core (master) and the memory responder (slave).
interface msrv32_dmem_responder_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] dmaddr;
  logic [WIDTH-1:0] dmdata_wr;
  logic [3:0]       dmwr_mask;
  logic             dmwr_req;
  logic             dmrd_req;
  logic [WIDTH-1:0] dmdata_rd;
  logic             hold_c;
  logic             ack;
  logic             dmrd_valid;
  logic             err;

  modport master (
    output dmaddr, dmdata_wr, dmwr_mask, dmwr_req, dmrd_req,
    input  dmdata_rd, hold_c, ack, dmrd_valid, err
  );

  modport slave (
    input  dmaddr, dmdata_wr, dmwr_mask, dmwr_req, dmrd_req,
    output dmdata_rd, hold_c, ack, dmrd_valid, err
  );
endinterface

// File: rtl/msrv32_dmem_responder.sv
// Data-memory responder: byte-maskable word array behind a fixed wait-state handshake.
module msrv32_dmem_responder #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                          ms_riscv32_mp_clk_in,
  input  logic                          ms_riscv32_mp_rst_in,
  msrv32_dmem_responder_if.slave        bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned IW = WIDTH - 2;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [IW-1:0]    waddr_q, waddr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       mask_q, mask_d;
  logic             wr_q, wr_d;
  logic             both_q, both_d;

  logic [IW-1:0]    acc_waddr;
  logic [WIDTH-1:0] acc_data;
  logic [3:0]       acc_mask;
  logic             acc_wr;
  logic             acc_both;
  logic             in_range;
  logic             wr_en;
  logic             rd_en;

  logic [WIDTH-1:0] rdata;
  logic             ack, ack_d;
  logic             rd_valid, rd_valid_d;
  logic             err, err_d;
  logic             req;
  logic             unused_addr_lsb;

  logic [WIDTH-1:0] mem [DEPTH_WORDS];

  assign req             = bus.dmwr_req | bus.dmrd_req;
  assign unused_addr_lsb = ^bus.dmaddr[1:0];

  // State register.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) state <= IDLE;
    else                       state <= state_d;
  end

  // Next state, request latching and the access that fires on entry to RESP.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    waddr_d    = waddr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    wr_d       = wr_q;
    both_d     = both_q;
    acc_waddr  = waddr_q;
    acc_data   = data_q;
    acc_mask   = mask_q;
    acc_wr     = wr_q;
    acc_both   = both_q;
    ack_d      = 1'b0;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    case (state)
      IDLE, RESP: begin
        state_d = IDLE;
        if (req) begin
          waddr_d   = bus.dmaddr[WIDTH-1:2];
          data_d    = bus.dmdata_wr;
          mask_d    = bus.dmwr_mask;
          wr_d      = bus.dmwr_req;
          both_d    = bus.dmwr_req & bus.dmrd_req;
          // With no wait states the access happens on this edge from live inputs.
          acc_waddr = waddr_d;
          acc_data  = data_d;
          acc_mask  = mask_d;
          acc_wr    = wr_d;
          acc_both  = both_d;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_d = RESP;
        else           cnt_d   = cnt - CW'(1);
      end
      default: state_d = IDLE;
    endcase
    in_range = acc_waddr < IW'(DEPTH_WORDS);
    wr_en    = (state_d == RESP) && acc_wr && in_range;
    rd_en    = (state_d == RESP) && !acc_wr;
    if (state_d == RESP) begin
      ack_d      = 1'b1;
      rd_valid_d = !acc_wr;
      err_d      = acc_both | !in_range;
    end
  end

  // Latched request, wait counter and registered response outputs.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      cnt      <= '0;
      waddr_q  <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      wr_q     <= 1'b0;
      both_q   <= 1'b0;
      ack      <= 1'b0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
    end else begin
      cnt      <= cnt_d;
      waddr_q  <= waddr_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      wr_q     <= wr_d;
      both_q   <= both_d;
      ack      <= ack_d;
      rd_valid <= rd_valid_d;
      err      <= err_d;
      if (rd_en) rdata <= in_range ? mem[acc_waddr[AW-1:0]] : '0;
    end
  end

  // Byte-masked array write; contents survive reset.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_mask[b]) mem[acc_waddr[AW-1:0]][8*b +: 8] <= acc_data[8*b +: 8];
      end
    end
  end

  assign bus.hold_c     = (state == WAIT) | (((state == IDLE) | (state == RESP)) & req);
  assign bus.ack        = ack;
  assign bus.dmrd_valid = rd_valid;
  assign bus.err        = err;
  assign bus.dmdata_rd  = rdata;
endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// Directed bench for msrv32_dmem_responder with 0, 1 and 3 wait states.
module tb_msrv32_dmem_responder;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  msrv32_dmem_responder_if #(.WIDTH(32)) if0 ();
  msrv32_dmem_responder_if #(.WIDTH(32)) if1 ();
  msrv32_dmem_responder_if #(.WIDTH(32)) if3 ();

  msrv32_dmem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n), .bus(if0.slave));
  msrv32_dmem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_w1 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n), .bus(if1.slave));
  msrv32_dmem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_w3 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n), .bus(if3.slave));

  typedef struct packed {
    logic [31:0] data;
    logic        hold;
    logic        ack;
    logic        rv;
    logic        err;
  } obs_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic w, input logic r);
    case (sel)
      0: begin if0.dmaddr = a; if0.dmdata_wr = d; if0.dmwr_mask = m; if0.dmwr_req = w; if0.dmrd_req = r; end
      1: begin if1.dmaddr = a; if1.dmdata_wr = d; if1.dmwr_mask = m; if1.dmwr_req = w; if1.dmrd_req = r; end
      default: begin if3.dmaddr = a; if3.dmdata_wr = d; if3.dmwr_mask = m; if3.dmwr_req = w; if3.dmrd_req = r; end
    endcase
  endtask

  task automatic sample(input int sel, output obs_t o);
    case (sel)
      0: o = '{data: if0.dmdata_rd, hold: if0.hold_c, ack: if0.ack, rv: if0.dmrd_valid, err: if0.err};
      1: o = '{data: if1.dmdata_rd, hold: if1.hold_c, ack: if1.ack, rv: if1.dmrd_valid, err: if1.err};
      default: o = '{data: if3.dmdata_rd, hold: if3.hold_c, ack: if3.ack, rv: if3.dmrd_valid, err: if3.err};
    endcase
  endtask

  // One request pulsed for a single cycle; returns the ack-cycle outputs and hold cycle count.
  task automatic access(input int sel, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic w, input logic r,
                        output obs_t o, output int hold_cnt);
    obs_t s;
    logic done;
    drive(sel, a, d, m, w, r);
    #1;
    sample(sel, s);
    hold_cnt = s.hold ? 1 : 0;
    @(posedge clk); #1;
    drive(sel, a, d, m, 1'b0, 1'b0);
    #1;
    done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sample(sel, s);
      if (s.ack) begin
        done = 1'b1;
        break;
      end
      if (s.hold) hold_cnt++;
      @(posedge clk); #1;
    end
    chk("ack_within_budget", 32'(done), 32'd1);
    o = s;
  endtask

  obs_t o;
  int   h;

  initial begin
    drive(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    drive(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    drive(3, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sample(1, o);
    chk("rst_ack", 32'(o.ack), 32'd0);
    chk("rst_rv", 32'(o.rv), 32'd0);
    chk("rst_err", 32'(o.err), 32'd0);
    chk("rst_hold", 32'(o.hold), 32'd0);
    chk("rst_data", o.data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One wait state: full-word write then read back.
    access(1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b0, o, h);
    chk("w1_wr_hold_cycles", 32'(h), 32'd2);
    chk("w1_wr_ack", 32'(o.ack), 32'd1);
    chk("w1_wr_rv", 32'(o.rv), 32'd0);
    chk("w1_wr_err", 32'(o.err), 32'd0);
    chk("w1_wr_hold_in_ack", 32'(o.hold), 32'd0);
    access(1, 32'h10, 32'h0, 4'b0000, 1'b0, 1'b1, o, h);
    chk("w1_rd_hold_cycles", 32'(h), 32'd2);
    chk("w1_rd_rv", 32'(o.rv), 32'd1);
    chk("w1_rd_data", o.data, 32'hDEADBEEF);

    // Byte and half-word lanes; writes leave read data untouched.
    access(1, 32'h10, 32'h0000AA00, 4'b0010, 1'b1, 1'b0, o, h);
    chk("w1_wr_keeps_rdata", o.data, 32'hDEADBEEF);
    access(1, 32'h10, 32'h12340000, 4'b1100, 1'b1, 1'b0, o, h);
    access(1, 32'h10, 32'h0, 4'b0000, 1'b0, 1'b1, o, h);
    chk("w1_lane_merge", o.data, 32'h1234AAEF);

    // Empty mask: acked, no error, no change.
    access(1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b1, 1'b0, o, h);
    chk("mask0_ack", 32'(o.ack), 32'd1);
    chk("mask0_err", 32'(o.err), 32'd0);
    access(1, 32'h10, 32'h0, 4'b0000, 1'b0, 1'b1, o, h);
    chk("mask0_unchanged", o.data, 32'h1234AAEF);

    // Out-of-range accesses; word 0 would alias if the range check were missing.
    access(1, 32'h0, 32'h01020304, 4'b1111, 1'b1, 1'b0, o, h);
    access(1, 32'h1000, 32'h0, 4'b0000, 1'b0, 1'b1, o, h);
    chk("oor_rd_err", 32'(o.err), 32'd1);
    chk("oor_rd_rv", 32'(o.rv), 32'd1);
    chk("oor_rd_data", o.data, 32'h0);
    access(1, 32'h1000, 32'hCAFEF00D, 4'b1111, 1'b1, 1'b0, o, h);
    chk("oor_wr_err", 32'(o.err), 32'd1);
    chk("oor_wr_rv", 32'(o.rv), 32'd0);
    access(1, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b1, o, h);
    chk("oor_wr_suppressed", o.data, 32'h01020304);
    chk("inrange_rd_err", 32'(o.err), 32'd0);

    // Simultaneous write and read: write wins, read dropped, error flagged.
    access(1, 32'h40, 32'h55AA55AA, 4'b1111, 1'b1, 1'b1, o, h);
    chk("both_ack", 32'(o.ack), 32'd1);
    chk("both_err", 32'(o.err), 32'd1);
    chk("both_rv", 32'(o.rv), 32'd0);
    chk("both_rdata_kept", o.data, 32'h01020304);
    access(1, 32'h40, 32'h0, 4'b0000, 1'b0, 1'b1, o, h);
    chk("both_wr_committed", o.data, 32'h55AA55AA);

    // Zero wait states: back-to-back write then read with request held high.
    drive(0, 32'h20, 32'hA5A50F0F, 4'b1111, 1'b1, 1'b0);
    #1;
    sample(0, o);
    chk("w0_hold_req", 32'(o.hold), 32'd1);
    @(posedge clk); #1;
    sample(0, o);
    chk("w0_wr_ack", 32'(o.ack), 32'd1);
    chk("w0_wr_rv", 32'(o.rv), 32'd0);
    drive(0, 32'h20, 32'h0, 4'b0000, 1'b0, 1'b1);
    #1;
    sample(0, o);
    chk("w0_hold_b2b", 32'(o.hold), 32'd1);
    @(posedge clk); #1;
    sample(0, o);
    chk("w0_rd_ack", 32'(o.ack), 32'd1);
    chk("w0_rd_rv", 32'(o.rv), 32'd1);
    chk("w0_raw_data", o.data, 32'hA5A50F0F);
    drive(0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0);
    #1;
    sample(0, o);
    chk("w0_hold_released", 32'(o.hold), 32'd0);
    @(posedge clk); #1;
    sample(0, o);
    chk("w0_ack_single", 32'(o.ack), 32'd0);

    // Three wait states, then reset in the middle of a write.
    access(3, 32'h50, 32'h11223344, 4'b1111, 1'b1, 1'b0, o, h);
    chk("w3_wr_hold_cycles", 32'(h), 32'd4);
    access(3, 32'h50, 32'h0, 4'b0000, 1'b0, 1'b1, o, h);
    chk("w3_rd_data", o.data, 32'h11223344);
    drive(3, 32'h50, 32'hFFFFFFFF, 4'b1111, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(3, 32'h50, 32'hFFFFFFFF, 4'b1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    sample(3, o);
    chk("w3_hold_in_wait", 32'(o.hold), 32'd1);
    rst_n = 1'b0;
    #1;
    sample(3, o);
    chk("midrst_hold", 32'(o.hold), 32'd0);
    chk("midrst_ack", 32'(o.ack), 32'd0);
    chk("midrst_data", o.data, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(3, 32'h50, 32'h0, 4'b0000, 1'b0, 1'b1, o, h);
    chk("midrst_no_commit", o.data, 32'h11223344);
    chk("midrst_rd_err", 32'(o.err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
